canny_row_sequencer: RTL and testbench
======================================

Name: canny_row_sequencer

Overview:
Sequences one full edge-detection frame over the shared image BRAMs. Streams every image row out of the source BRAM, hands each row to the convolution stage and writes the result row back to the output region. After the last row it runs the NMS and thresholding passes, each with a start/done handshake. It sits between the top-level enable/start and the convolution, NMS and threshold datapaths, and owns all BRAM row addressing.

Parameters:
IMG_W, 64, pixels per row (>=2)
IMG_H, 64, rows per frame (>=1)
ADDR_WIDTH, 12, BRAM address width
OUT_BASE, 2048, first BRAM address of the output image region
TIMEOUT_CYCLES, 4096, watchdog limit (only with optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  frame start request, sampled in IDLE only
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the frame completes
rd_en  out  1  source BRAM read strobe
rd_addr  out  ADDR_WIDTH  source read address
wr_en  out  1  output BRAM write strobe
wr_addr  out  ADDR_WIDTH  output write address
conv_start  out  1  one-cycle pulse: row loaded, convolve
conv_done  in  1  convolution finished (level or pulse)
nms_start  out  1  one-cycle pulse
nms_done  in  1  NMS finished
thr_start  out  1  one-cycle pulse
thr_done  in  1  thresholding finished
row_idx  out  clog2(IMG_H)  current row number
error  out  1  sticky watchdog flag (0 when feature is off)

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0. Reset mid-frame aborts immediately. No further strobes are issued.
- All outputs are registered.
- IDLE: if start=1, go to FETCH next cycle. Row counter and column counter are cleared, busy is set.
- FETCH: rd_en=1 for exactly IMG_W consecutive cycles. rd_addr = row*IMG_W + col, with col running 0..IMG_W-1.
  - Addresses come from an incrementing pointer, not a multiplier. The pointer is truncated to ADDR_WIDTH, so addresses wrap modulo 2^ADDR_WIDTH.
  - On the last column, go to CONV.
- CONV: conv_start=1 for one cycle, then WAIT_CONV.
- WAIT_CONV: conv_done is sampled only in this state. A conv_done that arrives during the conv_start cycle or earlier is ignored. On conv_done=1, go to WRITE.
- WRITE: wr_en=1 for IMG_W cycles, with wr_addr = OUT_BASE + row*IMG_W + col (wraps like rd_addr). On the last column:
  - if row==IMG_H-1, go to NMS;
  - otherwise row++ and go to FETCH.
- NMS: nms_start pulse, then WAIT_NMS until nms_done=1.
- THR: thr_start pulse, then WAIT_THR until thr_done=1.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE. start is ignored while busy. A start coinciding with the done cycle is also ignored.
- rd_en and wr_en are never high in the same cycle. At most one *_start pulse is high per cycle.
- Latency with start accepted at cycle 0:
  - first rd_en at cycle 1;
  - conv_start at cycle IMG_W+1.

Optional Feature:
CANNY_SEQ_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT_CONV, WAIT_NMS and WAIT_THR and clears on every state entry.
  - If it reaches TIMEOUT_CYCLES before the done input arrives, the block sets error=1 (sticky until reset), drops busy and returns to IDLE without pulsing done.
  - A new start clears nothing: error stays set.
- Undefined: no counter, waits are unbounded, error is tied to 0.

Test Plan:
- Full frame, IMG_W=4, IMG_H=2, OUT_BASE=16, conv_done returned 3 cycles after each conv_start:
  - reads hit addresses 0-3, then 4-7;
  - writes hit 16-19, then 20-23;
  - nms_start and thr_start each pulse once;
  - done pulses once, and busy is low after it.
- Early done: conv_done held high during the conv_start cycle, then low for 2 cycles, then high -> WRITE begins only after the later high.
- start pulsed mid-frame and in the done cycle -> no restart; exactly one done per accepted start.
- Reset asserted during the second WRITE cycle -> wr_en, busy and all start pulses drop to 0 asynchronously. After release the block stays in IDLE until the next start.
- Address wrap, ADDR_WIDTH=4, IMG_W=4, IMG_H=2, OUT_BASE=12 -> the second row's writes go to 0-3.
- With CANNY_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8 and nms_done never asserted -> error=1 and return to IDLE 8 cycles after entering WAIT_NMS, with no done pulse.

Source files
------------

// File: rtl/canny_row_sequencer.sv
// canny_row_sequencer: per-frame row fetch / convolve / write-back, then NMS and threshold passes.
// Optional wait-state watchdog enabled by defining CANNY_SEQ_TIMEOUT_EN.
module canny_row_sequencer #(
  parameter int IMG_W          = 64,
  parameter int IMG_H          = 64,
  parameter int ADDR_WIDTH     = 12,
  parameter int OUT_BASE       = 2048,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  conv_start,
  input  logic                  conv_done,
  output logic                  nms_start,
  input  logic                  nms_done,
  output logic                  thr_start,
  input  logic                  thr_done,
  output logic [RW-1:0]         row_idx,
  output logic                  error
);

  localparam int CW = $clog2(IMG_W);
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_CONV,
    S_WCONV,
    S_WRITE,
    S_NMS,
    S_WNMS,
    S_THR,
    S_WTHR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          last_col;
  logic          last_row;

  logic busy_q, done_q, rd_en_q, wr_en_q;
  logic cs_q, ns_q, ts_q;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

`ifdef CANNY_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          in_wait;
  assign in_wait = (state_q == S_WCONV) || (state_q == S_WNMS)
                || (state_q == S_WTHR);
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          col_d   = '0;
          row_d   = '0;
          rptr_d  = '0;
          wptr_d  = AW'(OUT_BASE);
        end
      end
      S_FETCH: begin
        rptr_d = rptr_q + AW'(1);
        if (last_col) begin
          col_d   = '0;
          state_d = S_CONV;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_CONV:  state_d = S_WCONV;
      S_WCONV: if (conv_done) state_d = S_WRITE;
      S_WRITE: begin
        wptr_d = wptr_q + AW'(1);
        if (last_col) begin
          col_d = '0;
          if (last_row) begin
            state_d = S_NMS;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = S_FETCH;
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_NMS:   state_d = S_WNMS;
      S_WNMS:  if (nms_done) state_d = S_THR;
      S_THR:   state_d = S_WTHR;
      S_WTHR:  if (thr_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef CANNY_SEQ_TIMEOUT_EN
    tmo_d = '0;
    err_d = err_q;
    // Still waiting: count, and abandon the frame once the limit is hit.
    if (in_wait && state_d == state_q) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      cs_q    <= 1'b0;
      ns_q    <= 1'b0;
      ts_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      rd_en_q <= (state_d == S_FETCH);
      wr_en_q <= (state_d == S_WRITE);
      cs_q    <= (state_d == S_CONV);
      ns_q    <= (state_d == S_NMS);
      ts_q    <= (state_d == S_THR);
    end
  end

`ifdef CANNY_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rptr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wptr_q;
  assign conv_start = cs_q;
  assign nms_start  = ns_q;
  assign thr_start  = ts_q;
  assign row_idx    = row_q;

endmodule

// File: tb/tb_canny_row_sequencer.sv
// Directed bench for canny_row_sequencer: 4x2 frame, base 16, plus a
// 4-bit-address twin (base 12) sharing the same stimulus for wrap checks.
module tb_canny_row_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic conv_done = 1'b0;
  logic nms_done = 1'b0;
  logic thr_done = 1'b0;

  logic        busy, done, rd_en, wr_en;
  logic        conv_start, nms_start, thr_start, error;
  logic [11:0] rd_addr, wr_addr;
  logic [0:0]  row_idx;

  logic        busy2, done2, rd_en2, wr_en2;
  logic        conv_start2, nms_start2, thr_start2, error2;
  logic [3:0]  rd_addr2, wr_addr2;
  logic [0:0]  row_idx2;

  int errors = 0;
  int checks = 0;

  int rd_log[$];
  int wr_log[$];
  int wr2_log[$];
  int row_log[$];
  int n_conv, n_nms, n_thr, n_done, overlap, multi;
  int first_rd, first_conv, first_wr, done_cyc, last_busy, first_err;
  logic busy_at_done;

  canny_row_sequencer #(
    .IMG_W(4), .IMG_H(2), .ADDR_WIDTH(12),
    .OUT_BASE(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .conv_start(conv_start), .conv_done(conv_done),
    .nms_start(nms_start), .nms_done(nms_done),
    .thr_start(thr_start), .thr_done(thr_done),
    .row_idx(row_idx), .error(error)
  );

  canny_row_sequencer #(
    .IMG_W(4), .IMG_H(2), .ADDR_WIDTH(4),
    .OUT_BASE(12), .TIMEOUT_CYCLES(8)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2),
    .wr_en(wr_en2), .wr_addr(wr_addr2),
    .conv_start(conv_start2), .conv_done(conv_done),
    .nms_start(nms_start2), .nms_done(nms_done),
    .thr_start(thr_start2), .thr_done(thr_done),
    .row_idx(row_idx2), .error(error2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; k counts cycles with the start-accept edge as cycle 0.
  task automatic run_frame(input int clat, input bit early,
                           input int nlat, input bit poke,
                           input int maxc);
    int ct, nt, tt, k;
    rd_log.delete(); wr_log.delete(); wr2_log.delete(); row_log.delete();
    n_conv = 0; n_nms = 0; n_thr = 0; n_done = 0;
    overlap = 0; multi = 0;
    first_rd = -1; first_conv = -1; first_wr = -1;
    done_cyc = -1; last_busy = -1; first_err = -1;
    busy_at_done = 1'bx;
    ct = -1; nt = -1; tt = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (k <= maxc) begin
      conv_done = 1'b0;
      nms_done  = 1'b0;
      thr_done  = 1'b0;
      start     = 1'b0;
      if (rd_en) begin
        rd_log.push_back(int'(rd_addr));
        if (first_rd < 0) first_rd = k;
      end
      if (wr_en) begin
        wr_log.push_back(int'(wr_addr));
        wr2_log.push_back(int'(wr_addr2));
        if (first_wr < 0) first_wr = k;
      end
      if (rd_en && wr_en) overlap++;
      if (int'(conv_start) + int'(nms_start) + int'(thr_start) > 1) multi++;
      if (conv_start) begin
        n_conv++;
        if (first_conv < 0) first_conv = k;
        row_log.push_back(int'(row_idx));
      end
      if (nms_start) n_nms++;
      if (thr_start) n_thr++;
      if (busy) last_busy = k;
      if (error && first_err < 0) first_err = k;
      if (done) begin
        n_done++;
        done_cyc = k;
        busy_at_done = busy;
        if (poke) start = 1'b1;
      end
      if (poke && k == 10) start = 1'b1;
      if (conv_start) ct = clat;
      else if (ct > 0) ct--;
      if (ct == 0) begin conv_done = 1'b1; ct = -1; end
      if (early && (rd_en || conv_start)) conv_done = 1'b1;
      if (nms_start && nlat >= 0) nt = nlat;
      else if (nt > 0) nt--;
      if (nt == 0) begin nms_done = 1'b1; nt = -1; end
      if (thr_start) tt = 2;
      else if (tt > 0) tt--;
      if (tt == 0) begin thr_done = 1'b1; tt = -1; end
      if (done_cyc >= 0 && k >= done_cyc + 6) break;
      step();
      k++;
    end
    conv_done = 1'b0;
    nms_done  = 1'b0;
    thr_done  = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    repeat (2) @(posedge clk);
    #1;
    obs = {busy, done, rd_en, wr_en, conv_start, nms_start, thr_start, error};
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: outputs=%b expected=%b", obs, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    obs = {busy, done, rd_en, wr_en, conv_start, nms_start, thr_start, error};
    checks++;
    if (obs !== 8'h00 || rd_addr !== 12'd0 || row_idx !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%b rd_addr=%0d expected=0", obs, rd_addr);
    end
  endtask

  task automatic test_full_frame();
    int exp_rd[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int exp_wr[8]  = '{16, 17, 18, 19, 20, 21, 22, 23};
    int got;
    run_frame(3, 1'b0, 2, 1'b0, 60);
    checks++;
    if (rd_log.size() != 8 || wr_log.size() != 8) begin
      errors++;
      $display("FAIL ff_counts: rd=%0d wr=%0d expected=8/8", rd_log.size(), wr_log.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : -1;
      checks++;
      if (got != exp_rd[i]) begin
        errors++;
        $display("FAIL ff_rd_addr[%0d]: got=%0d expected=%0d", i, got, exp_rd[i]);
      end
      got = (i < wr_log.size()) ? wr_log[i] : -1;
      checks++;
      if (got != exp_wr[i]) begin
        errors++;
        $display("FAIL ff_wr_addr[%0d]: got=%0d expected=%0d", i, got, exp_wr[i]);
      end
    end
    checks++;
    if (first_rd != 1 || first_conv != 5 || first_wr != 9) begin
      errors++;
      $display("FAIL ff_latency: rd=%0d conv=%0d wr=%0d expected=1/5/9",
               first_rd, first_conv, first_wr);
    end
    checks++;
    if (n_conv != 2 || n_nms != 1 || n_thr != 1) begin
      errors++;
      $display("FAIL ff_pulses: conv=%0d nms=%0d thr=%0d expected=2/1/1",
               n_conv, n_nms, n_thr);
    end
    checks++;
    if (n_done != 1 || done_cyc != 31) begin
      errors++;
      $display("FAIL ff_done: count=%0d cycle=%0d expected=1 at 31", n_done, done_cyc);
    end
    checks++;
    if (busy_at_done !== 1'b0 || last_busy != 30 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ff_busy: at_done=%b last=%0d expected=0 and 30", busy_at_done, last_busy);
    end
    checks++;
    if (overlap != 0 || multi != 0) begin
      errors++;
      $display("FAIL ff_exclusive: overlap=%0d multi=%0d expected=0/0", overlap, multi);
    end
    checks++;
    if (row_log.size() != 2 || row_log[0] != 0 || row_log[1] != 1) begin
      errors++;
      $display("FAIL ff_row_idx: n=%0d expected rows 0,1", row_log.size());
    end
  endtask

  task automatic test_early_done();
    run_frame(3, 1'b1, 2, 1'b0, 60);
    checks++;
    if (first_wr != 9) begin
      errors++;
      $display("FAIL early_first_wr: got=%0d expected=9", first_wr);
    end
    checks++;
    if (n_done != 1 || done_cyc != 31 || wr_log.size() != 8) begin
      errors++;
      $display("FAIL early_frame: done=%0d at %0d wr=%0d expected=1 at 31, 8",
               n_done, done_cyc, wr_log.size());
    end
  endtask

  task automatic test_start_ignored();
    bit restarted;
    run_frame(3, 1'b0, 2, 1'b1, 60);
    checks++;
    if (n_done != 1 || done_cyc != 31) begin
      errors++;
      $display("FAIL poke_done: count=%0d cycle=%0d expected=1 at 31", n_done, done_cyc);
    end
    checks++;
    if (rd_log.size() != 8 || last_busy != 30) begin
      errors++;
      $display("FAIL poke_restart: reads=%0d last_busy=%0d expected=8 and 30",
               rd_log.size(), last_busy);
    end
    restarted = 1'b0;
    repeat (6) begin
      step();
      if (busy || rd_en || done) restarted = 1'b1;
    end
    checks++;
    if (restarted) begin
      errors++;
      $display("FAIL poke_idle: activity=%b expected=0", restarted);
    end
  endtask

  task automatic test_reset_midframe();
    int nwr, k;
    bit act;
    logic [6:0] obs;
    nwr = 0;
    k = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (nwr < 2 && k < 40) begin
      if (wr_en) nwr++;
      if (nwr < 2) begin
        conv_done = busy && !rd_en && !wr_en && !conv_start;
        step();
        k++;
      end
    end
    conv_done = 1'b0;
    checks++;
    if (nwr != 2) begin
      errors++;
      $display("FAIL rst_reach_write: writes=%0d expected=2", nwr);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {busy, done, rd_en, wr_en, conv_start, nms_start, thr_start};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL rst_async: outputs=%b expected=%b", obs, 7'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    act = 1'b0;
    repeat (8) begin
      step();
      if (busy || rd_en || wr_en || conv_start || done) act = 1'b1;
    end
    checks++;
    if (act) begin
      errors++;
      $display("FAIL rst_stay_idle: activity=%b expected=0", act);
    end
  endtask

  task automatic test_addr_wrap();
    int exp_w2[8] = '{12, 13, 14, 15, 0, 1, 2, 3};
    int got;
    run_frame(3, 1'b0, 2, 1'b0, 60);
    for (int i = 0; i < 8; i++) begin
      got = (i < wr2_log.size()) ? wr2_log[i] : -1;
      checks++;
      if (got != exp_w2[i]) begin
        errors++;
        $display("FAIL wrap_wr_addr[%0d]: got=%0d expected=%0d", i, got, exp_w2[i]);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef CANNY_SEQ_TIMEOUT_EN
    run_frame(3, 1'b0, -1, 1'b0, 45);
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL tmo_no_done: count=%0d expected=0", n_done);
    end
    checks++;
    if (first_err != 34 || last_busy != 33 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: err_at=%0d last_busy=%0d expected=34 and 33",
               first_err, last_busy);
    end
    run_frame(3, 1'b0, 2, 1'b0, 60);
    checks++;
    if (error !== 1'b1 || n_done != 1 || done_cyc != 31) begin
      errors++;
      $display("FAIL tmo_sticky: error=%b done=%0d at %0d expected=1, 1 at 31",
               error, n_done, done_cyc);
    end
`else
    run_frame(3, 1'b0, 20, 1'b0, 80);
    checks++;
    if (n_done != 1 || done_cyc != 49) begin
      errors++;
      $display("FAIL long_wait_done: count=%0d cycle=%0d expected=1 at 49", n_done, done_cyc);
    end
    checks++;
    if (first_err != -1 || error !== 1'b0) begin
      errors++;
      $display("FAIL long_wait_error: err_at=%0d expected=none", first_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_done();
    test_start_ignored();
    test_reset_midframe();
    test_addr_wrap();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
